// File: rtl/sid_pkg.sv
// Shared SID register-bus definitions: field widths, register map landmarks and
// the queued write record used by the write arbiter.
package sid_pkg;

    localparam int SID_ADDR_W = 5;
    localparam int SID_DATA_W = 8;

    localparam logic [SID_ADDR_W-1:0] SID_REG_LAST    = 5'h18;
    localparam logic [SID_ADDR_W-1:0] SID_VOICE1_BASE = 5'h00;
    localparam logic [SID_ADDR_W-1:0] SID_VOICE2_BASE = 5'h07;
    localparam logic [SID_ADDR_W-1:0] SID_VOICE3_BASE = 5'h0E;
    localparam logic [SID_ADDR_W-1:0] SID_FILTER_BASE = 5'h15;

    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sidWrite_t;

    // Addresses above the last writable register are read-only or unmapped.
    function automatic logic isMapped(input logic [SID_ADDR_W-1:0] addr);
        return addr <= SID_REG_LAST;
    endfunction

endpackage

// File: rtl/sid_write_fifo.sv
// Synchronous FIFO of SID register writes with an occupancy count.
// The head entry is visible combinationally; the caller never pushes when full.
module sid_write_fifo
    import sid_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iPush,
    input  sidWrite_t          iWrite,
    input  logic               iPop,
    output sidWrite_t          oHead,
    output logic [LEVEL_W-1:0] oLevel
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    sidWrite_t          mem [DEPTH];
    logic [PTR_W-1:0]   wrPtrQ;
    logic [PTR_W-1:0]   rdPtrQ;
    logic [LEVEL_W-1:0] levelQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            levelQ <= '0;
        end else begin
            if (iPush) wrPtrQ <= wrPtrQ + 1'b1;
            if (iPop)  rdPtrQ <= rdPtrQ + 1'b1;
            unique case ({iPush, iPop})
                2'b10:   levelQ <= levelQ + 1'b1;
                2'b01:   levelQ <= levelQ - 1'b1;
                default: levelQ <= levelQ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the level covers them.
    always_ff @(posedge clk) begin
        if (iPush) mem[wrPtrQ] <= iWrite;
    end

    assign oHead  = mem[rdPtrQ];
    assign oLevel = levelQ;

endmodule

// File: rtl/sid_write_arbiter.sv
// Round-robin arbiter sharing the SID register write bus between requesters,
// queueing accepted writes and draining them as single-cycle strobes with a gap.
module sid_write_arbiter
    import sid_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP        = 0,
    localparam int unsigned LEVEL_W   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            iValid,
    input  logic [SID_ADDR_W*NREQ-1:0] iAddr,
    input  logic [SID_DATA_W*NREQ-1:0] iData,
    output logic [NREQ-1:0]            oReady,
    input  logic                       iHold,
    output logic                       oWE,
    output logic [SID_ADDR_W-1:0]      oAddr,
    output logic [SID_DATA_W-1:0]      oData,
    output logic                       oDropped,
    output logic [LEVEL_W-1:0]         oLevel
);

    localparam int unsigned RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [RR_W-1:0]            rrQ;
    logic [RR_W-1:0]            grantIdx;
    logic                       grantFound;
    logic [NREQ-1:0]            validShift;
    int unsigned                rrWide;
    logic                       full;
    logic                       transfer;
    logic                       pushEn;
    logic                       popEn;
    logic [7:0]                 gapQ;
    logic [SID_ADDR_W*NREQ-1:0] addrShift;
    logic [SID_DATA_W*NREQ-1:0] dataShift;
    sidWrite_t                  selWrite;
    sidWrite_t                  headWrite;

    // Pass 0 scans requesters at or above the pointer, pass 1 wraps to those below.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        validShift = '0;
        rrWide     = 32'(rrQ);
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                validShift = iValid >> j;
                if (!grantFound && validShift[0] && ((p == 0) == (j >= rrWide))) begin
                    grantFound = 1'b1;
                    grantIdx   = RR_W'(j);
                end
            end
        end
    end

    // Fullness uses the registered level so a same-cycle pop never opens a grant.
    assign full     = (oLevel == LEVEL_W'(FIFO_DEPTH));
    assign oReady   = (grantFound && !full) ? (NREQ'(1) << grantIdx) : '0;
    assign transfer = |(iValid & oReady);

    always_comb begin
        addrShift     = iAddr >> (SID_ADDR_W * grantIdx);
        dataShift     = iData >> (SID_DATA_W * grantIdx);
        selWrite.addr = addrShift[SID_ADDR_W-1:0];
        selWrite.data = dataShift[SID_DATA_W-1:0];
    end

    assign pushEn = transfer && isMapped(selWrite.addr);
    assign popEn  = (oLevel != '0) && !iHold && (gapQ == 8'd0);

    sid_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .iPush  (pushEn),
        .iWrite (selWrite),
        .iPop   (popEn),
        .oHead  (headWrite),
        .oLevel (oLevel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrQ      <= '0;
            gapQ     <= 8'd0;
            oWE      <= 1'b0;
            oAddr    <= '0;
            oData    <= '0;
            oDropped <= 1'b0;
        end else begin
            oWE      <= popEn;
            oDropped <= transfer && !isMapped(selWrite.addr);
            if (transfer) begin
                rrQ <= (grantIdx == RR_W'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
            end
            // Gap keeps counting through iHold so a long stall does not add spacing.
            if (popEn) begin
                oAddr <= headWrite.addr;
                oData <= headWrite.data;
                gapQ  <= 8'(GAP);
            end else if (gapQ != 8'd0) begin
                gapQ <= gapQ - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sid_write_arbiter.sv
// Bench for sid_write_arbiter: a GAP=0 and a GAP=3 instance share stimulus and are
// each compared every cycle against a queue-based reference model.
module tb_sid_write_arbiter;

    localparam int NI    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  vld;
    logic [9:0]  addrIn;
    logic [15:0] dataIn;
    logic        hold;

    logic [1:0] ready   [NI];
    logic       we      [NI];
    logic [4:0] addrO   [NI];
    logic [7:0] dataO   [NI];
    logic       dropped [NI];
    logic [2:0] level   [NI];

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : gInst
        sid_write_arbiter #(
            .NREQ       (2),
            .FIFO_DEPTH (DEPTH),
            .GAP        ((k == 0) ? 0 : 3)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .iValid   (vld),
            .iAddr    (addrIn),
            .iData    (dataIn),
            .oReady   (ready[k]),
            .iHold    (hold),
            .oWE      (we[k]),
            .oAddr    (addrO[k]),
            .oData    (dataO[k]),
            .oDropped (dropped[k]),
            .oLevel   (level[k])
        );
    end

    // Reference model state per instance.
    logic [12:0] mq [NI][$];
    int          rr      [NI];
    int          gap     [NI];
    logic        expWE   [NI];
    logic        expDrop [NI];
    logic [4:0]  expAddr [NI];
    logic [7:0]  expData [NI];

    function automatic int gapOf(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int grantOf(input int k);
        int r;
        logic [1:0] v;
        if (mq[k].size() >= DEPTH) return -1;
        for (int i = 0; i < 2; i++) begin
            r = (rr[k] + i) % 2;
            v = vld >> r;
            if (v[0]) return r;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NI; k++) begin
            mq[k].delete();
            rr[k]      = 0;
            gap[k]     = 0;
            expWE[k]   = 1'b0;
            expDrop[k] = 1'b0;
            expAddr[k] = 5'h00;
            expData[k] = 8'h00;
        end
    endtask

    task automatic modelStep(input int k);
        int          g;
        logic        pop;
        logic [12:0] head;
        logic [9:0]  a;
        logic [15:0] d;
        g   = grantOf(k);
        pop = (mq[k].size() > 0) && !hold && (gap[k] == 0);
        expWE[k] = pop;
        if (pop) begin
            head       = mq[k].pop_front();
            expAddr[k] = head[12:8];
            expData[k] = head[7:0];
            gap[k]     = gapOf(k);
        end else if (gap[k] > 0) begin
            gap[k]--;
        end
        expDrop[k] = 1'b0;
        if (g >= 0) begin
            a = addrIn >> (5 * g);
            d = dataIn >> (8 * g);
            if (a[4:0] <= 5'd24) mq[k].push_back({a[4:0], d[7:0]});
            else                 expDrop[k] = 1'b1;
            rr[k] = (g + 1) % 2;
        end
    endtask

    // Check at the falling edge, advance the model at the rising edge, then return
    // 2 time units later so the caller can drive the next cycle's inputs.
    task automatic tick();
        int g;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            g = grantOf(k);
            check($sformatf("ready%0d", k), 32'(ready[k]), (g >= 0) ? (32'd1 << g) : 32'd0);
            check($sformatf("level%0d", k), 32'(level[k]), 32'(mq[k].size()));
            check($sformatf("we%0d", k), 32'(we[k]), 32'(expWE[k]));
            check($sformatf("addr%0d", k), 32'(addrO[k]), 32'(expAddr[k]));
            check($sformatf("data%0d", k), 32'(dataO[k]), 32'(expData[k]));
            check($sformatf("drop%0d", k), 32'(dropped[k]), 32'(expDrop[k]));
        end
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < NI; k++) modelStep(k);
        end
        #2;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [7:0] d0,
                         input logic [4:0] a1, input logic [7:0] d1);
        vld    = v;
        addrIn = {a1, a0};
        dataIn = {d1, d0};
    endtask

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        modelReset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // Single write: strobe two cycles after acceptance.
        drive(2'b01, 5'h01, 8'h1C, 5'h00, 8'h00);
        tick();
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        repeat (5) tick();
        check("single_addr", 32'(addrO[0]), 32'h01);
        check("single_data", 32'(dataO[0]), 32'h1C);

        // Round-robin with both requesters continuously valid.
        for (int i = 0; i < 16; i++) begin
            drive(2'b11, 5'(i % 25), 8'(i), 5'(24 - (i % 25)), 8'(8'h80 + i));
            tick();
        end
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        repeat (30) tick();

        // Full and hold.
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, 5'(i + 2), 8'(8'h40 + i), 5'h00, 8'h00);
            tick();
        end
        check("full_level", 32'(level[0]), 32'd4);
        check("full_ready", 32'(ready[0]), 32'd0);
        hold = 1'b0;
        tick();
        drive(2'b01, 5'h0A, 8'h5A, 5'h00, 8'h00);
        tick();
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        repeat (30) tick();

        // Gap spacing on the GAP=3 instance.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 5'(5'h0E + i), 8'(8'hA0 + i), 5'h00, 8'h00);
            tick();
        end
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        hold = 1'b0;
        repeat (20) tick();

        // Drop: unmapped address from requester 1, then requester 0 wins next.
        drive(2'b10, 5'h00, 8'h00, 5'h1B, 8'hEE);
        tick();
        drive(2'b11, 5'h15, 8'h33, 5'h16, 8'h44);
        tick();
        check("drop_level", 32'(level[0]), 32'd1);
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        repeat (10) tick();

        // Asynchronous reset mid-cycle with writes queued behind hold.
        hold = 1'b1;
        drive(2'b11, 5'h03, 8'h11, 5'h04, 8'h22);
        repeat (3) tick();
        drive(2'b01, 5'h05, 8'h55, 5'h00, 8'h00);
        #4 rst = 1'b1;
        modelReset();
        #1;
        check("async_level", 32'(level[0]), 32'd0);
        check("async_ready", 32'(ready[0]), 32'b01);
        repeat (2) tick();
        rst  = 1'b0;
        hold = 1'b0;
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        repeat (8) tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom),
                  5'($urandom_range(0, 31)), 8'($urandom));
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                modelReset();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        drive(2'b00, 5'h00, 8'h00, 5'h00, 8'h00);
        hold = 1'b0;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
